accel_job_requester: RTL and testbench

Requester side of the accelerator's start/done handshake. Pops one operand per job from an input FIFO (first-word-fall-through), presents it to the accelerator, and pulses `acc_start`. It then waits for the accelerator's one-cycle `done` pulse, captures the result, and pushes it into an output FIFO. Sits in the accelerator wrapper between the input buffer, the accelerator core, and the output buffer.

---
 rtl/accel_wrap_pkg.sv | 6 +
 rtl/accel_job_requester_timeout_counter.sv | 18 +
 rtl/accel_job_requester.sv | 80 ++++++++
 tb/tb_accel_job_requester.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/accel_wrap_pkg.sv
// accel_wrap_pkg: shared state encoding and default widths for the accelerator wrapper
package accel_wrap_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} req_state_t;
  localparam int DATA_W_DEF = 8;
  localparam int RES_W_DEF = 16;
endpackage

// File: rtl/accel_job_requester_timeout_counter.sv
// timeout_counter: wait timer that flags the last allowed cycle (count == MAX-1)
module timeout_counter #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(MAX);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) r_cnt <= '0;
    else if (en) r_cnt <= r_cnt + W'(1);
  end
  assign expired = r_cnt == W'(MAX - 1);
endmodule

// File: rtl/accel_job_requester.sv
// accel_job_requester: pops an operand, starts the accelerator, waits for done, pushes the result
module accel_job_requester
  import accel_wrap_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_empty,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rd,
  output logic [DATA_W-1:0] acc_x,
  output logic              acc_start,
  input  logic              acc_done,
  input  logic [RES_W-1:0]  acc_res,
  input  logic              out_full,
  output logic              out_wr,
  output logic [RES_W-1:0]  out_data,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        job_count
);
  req_state_t        r_state;
  logic [DATA_W-1:0] r_x;
  logic [RES_W-1:0]  r_res;
  logic              r_err;
  logic [7:0]        r_count;
  logic              w_expired;

  assign in_rd       = r_state == IDLE && en && !in_empty;
  assign out_wr      = r_state == STORE && !out_full;
  assign acc_start   = r_state == ISSUE;
  assign busy        = r_state != IDLE;
  assign acc_x       = r_x;
  assign out_data    = r_res;
  assign timeout_err = r_err;
  assign job_count   = r_count;

  // timer freezes on done so a coincident expiry never counts past the window
  timeout_counter #(.MAX(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (r_state == ISSUE),
    .en     (r_state == WAIT && !acc_done && !w_expired),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_rd) begin
          r_x     <= in_data;
          r_state <= ISSUE;
        end
        ISSUE: r_state <= WAIT;
        WAIT: if (acc_done) begin
          r_res   <= acc_res;
          r_state <= STORE;
        end else if (w_expired) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end
        STORE: if (out_wr) begin
          r_count <= r_count + 8'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accel_job_requester.sv
// tb_accel_job_requester: directed checks of the job handshake with TIMEOUT=8
module tb_accel_job_requester;
  logic        clk = 1'b0;
  logic        rst, en, in_empty, acc_done, out_full;
  logic [7:0]  in_data;
  logic [15:0] acc_res;
  logic        in_rd, acc_start, out_wr, busy, timeout_err;
  logic [7:0]  acc_x, job_count;
  logic [15:0] out_data;
  int n_chk = 0;
  int n_fail = 0;

  accel_job_requester #(.DATA_W(8), .RES_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .in_empty(in_empty), .in_data(in_data),
    .in_rd(in_rd), .acc_x(acc_x), .acc_start(acc_start), .acc_done(acc_done),
    .acc_res(acc_res), .out_full(out_full), .out_wr(out_wr), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err), .job_count(job_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // entered in an IDLE cycle with the FIFO head presented; returns in the cycle after done
  task automatic do_job(input logic [7:0] x, input logic [15:0] r, input int lat,
                        input logic nxt_empty, input logic [7:0] nxt_data, input logic exp_wr);
    #1;
    chk("in_rd_fetch", in_rd, 1);
    step();
    in_empty = nxt_empty;
    in_data  = nxt_data;
    #1;
    chk("acc_start", acc_start, 1);
    chk("acc_x", acc_x, x);
    chk("in_rd_issue", in_rd, 0);
    repeat (lat) step();
    acc_done = 1'b1;
    acc_res  = r;
    #1;
    chk("out_wr_done_cycle", out_wr, 0);
    step();
    acc_done = 1'b0;
    acc_res  = 16'h0;
    #1;
    chk("out_wr_store", out_wr, exp_wr);
    chk("out_data_store", out_data, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; in_empty = 1'b1; in_data = 8'h0;
    acc_done = 1'b0; acc_res = 16'h0; out_full = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_acc_x", acc_x, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_rd", in_rd, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_job_count", job_count, 0);

    in_empty = 1'b0; in_data = 8'h2A;
    #1;
    chk("gate_in_rd", in_rd, 0);
    step();
    chk("gate_busy", busy, 0);

    en = 1'b1;
    do_job(8'h2A, 16'h1234, 4, 1'b1, 8'h0, 1'b1);
    chk("single_cnt_before", job_count, 0);
    step();
    chk("single_cnt", job_count, 1);
    chk("single_idle", busy, 0);

    in_empty = 1'b0; in_data = 8'h01;
    do_job(8'h01, 16'h0011, 4, 1'b0, 8'h02, 1'b1);
    step();
    do_job(8'h02, 16'h0022, 4, 1'b0, 8'h03, 1'b1);
    step();
    do_job(8'h03, 16'h0033, 4, 1'b1, 8'h00, 1'b1);
    step();
    chk("b2b_cnt", job_count, 4);

    in_empty = 1'b0; in_data = 8'h09; out_full = 1'b1;
    do_job(8'h09, 16'hCAFE, 4, 1'b1, 8'h00, 1'b0);
    chk("bp_busy", busy, 1);
    repeat (4) begin
      step();
      chk("bp_out_wr", out_wr, 0);
      chk("bp_out_data", out_data, 16'hCAFE);
      chk("bp_busy_hold", busy, 1);
    end
    step();
    out_full = 1'b0;
    #1;
    chk("bp_release_wr", out_wr, 1);
    chk("bp_release_data", out_data, 16'hCAFE);
    step();
    chk("bp_cnt", job_count, 5);
    chk("bp_idle", busy, 0);

    acc_done = 1'b1; acc_res = 16'hDEAD;
    #1;
    chk("spur_busy", busy, 0);
    step();
    acc_done = 1'b0; acc_res = 16'h0;
    #1;
    chk("spur_out_wr", out_wr, 0);
    chk("spur_out_data", out_data, 16'hCAFE);
    chk("spur_busy_after", busy, 0);
    chk("spur_cnt", job_count, 5);

    in_empty = 1'b0; in_data = 8'h55;
    #1;
    chk("to_in_rd", in_rd, 1);
    step();
    in_data = 8'h66;
    chk("to_start", acc_start, 1);
    step();
    chk("to_err_w1", timeout_err, 0);
    repeat (7) begin
      step();
      chk("to_err_low", timeout_err, 0);
      chk("to_out_wr", out_wr, 0);
      chk("to_busy", busy, 1);
    end
    step();
    chk("to_err_rise", timeout_err, 1);
    chk("to_idle", busy, 0);
    chk("to_cnt", job_count, 5);
    do_job(8'h66, 16'hBEEF, 4, 1'b1, 8'h00, 1'b1);
    step();
    chk("to_next_cnt", job_count, 6);
    chk("to_err_sticky", timeout_err, 1);

    in_empty = 1'b0; in_data = 8'h77;
    #1;
    chk("rw_in_rd", in_rd, 1);
    step();
    in_empty = 1'b1;
    step(); step();
    chk("rw_in_wait", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_acc_x", acc_x, 0);
    chk("rw_out_data", out_data, 0);
    chk("rw_acc_start", acc_start, 0);
    chk("rw_out_wr", out_wr, 0);
    chk("rw_cnt", job_count, 0);
    chk("rw_err", timeout_err, 0);
    acc_done = 1'b1; acc_res = 16'h5A5A;
    step();
    acc_done = 1'b0;
    #1;
    chk("rw_late_done_wr", out_wr, 0);
    chk("rw_late_done_data", out_data, 0);

    in_empty = 1'b0; in_data = 8'h3C;
    do_job(8'h3C, 16'h4242, 8, 1'b1, 8'h00, 1'b1);
    chk("coin_err", timeout_err, 0);
    step();
    chk("coin_cnt", job_count, 1);
    chk("coin_err_after", timeout_err, 0);

    en = 1'b0; in_empty = 1'b0; in_data = 8'h11;
    repeat (3) begin
      step();
      chk("gate2_in_rd", in_rd, 0);
      chk("gate2_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
